// File: rtl/ser_tx_shift.sv
// Parallel-in, serial-out transmitter: shifts a captured word out LSB-first with a bit-valid strobe.
// Optional trailing even-parity bit when TX_PARITY_EN is defined.
module ser_tx_shift #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] pi,
   output logic             so,
   output logic             so_vld,
   output logic             co,
   output logic             busy,
   output logic             done
);

`ifdef TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_bit;
`ifdef TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign busy     = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
`ifdef TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
`ifdef TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
`ifdef TX_PARITY_EN
      parity_d = parity_q;
`endif
      so       = 1'b0;
      so_vld   = 1'b0;
      co       = 1'b0;
      done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d  = pi;
               cnt_d    = '0;
`ifdef TX_PARITY_EN
               // Parity is taken from the word at capture, since shifting destroys it.
               parity_d = ^pi;
`endif
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            so_vld  = 1'b1;
            so      = shreg_q[0];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
`ifndef TX_PARITY_EN
            co      = last_bit;
`endif
            if (last_bit) begin
               cnt_d = '0;
`ifdef TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef TX_PARITY_EN
         PARITY: begin
            so_vld  = 1'b1;
            so      = parity_q;
            co      = 1'b1;
            state_d = DONE;
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
